argmax_frame_ctrl: RTL and testbench
====================================

// Module: argmax_frame_ctrl
// PURPOSE
//  Frame sequencer for the arg_max unit. On a start command it gates exactly frame_len I/Q
//  samples from an upstream stream into arg_max, marks the last sample and waits for
//  arg_max's (max, index) result. It then holds that result in an output register until
//  downstream accepts it. It sits between the CAF correlator output and arg_max.
// PARAMETERS
//  I_BITS        16   width of signed in-phase sample
//  Q_BITS        16   width of signed quadrature sample
//  OUT_MAX_BITS  33   width of arg_max magnitude result
//  INDEX_BITS    10   width of sample index / frame length
// PORTS
//  clk           in   1             system clock, rising edge
//  rst           in   1             asynchronous, active-high reset
//  start         in   1             single-cycle frame start request
//  frame_len     in   INDEX_BITS    samples per frame, sampled when start is accepted
//  s_xi          in   I_BITS        upstream I sample (signed)
//  s_xq          in   Q_BITS        upstream Q sample (signed)
//  s_valid       in   1             upstream sample valid
//  s_ready       out  1             upstream sample accepted
//  am_xi         out  I_BITS        sample to arg_max (I)
//  am_xq         out  Q_BITS        sample to arg_max (Q)
//  am_valid      out  1             sample valid to arg_max
//  am_ready      in   1             arg_max ready for a sample
//  am_last       out  1             marks final sample of the frame
//  am_max        in   OUT_MAX_BITS  arg_max magnitude result
//  am_index      in   INDEX_BITS    arg_max index result
//  am_res_valid  in   1             arg_max result valid
//  am_res_ready  out  1             controller ready for the arg_max result
//  res_max       out  OUT_MAX_BITS  registered frame maximum
//  res_index     out  INDEX_BITS    registered frame argmax index
//  res_valid     out  1             result held, awaiting res_ready
//  res_ready     in   1             downstream accepts result
//  busy          out  1             high in every state except IDLE
//  done          out  1             one-cycle pulse when a result is accepted downstream
//  idx_err       out  1             sticky: captured am_index >= latched frame_len
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; count=0, len_q=0; res_max=0, res_index=0.
//   All outputs below are 0 during reset: res_valid, done, idx_err, busy, s_ready,
//   am_valid, am_last, am_res_ready.
//  States: IDLE -> FEED -> WAIT -> HOLD -> IDLE.
//  IDLE: s_ready=0, am_valid=0.
//   start=1 and frame_len!=0: len_q<=frame_len, count<=0, idx_err<=0, go to FEED next cycle.
//   start with frame_len==0 is ignored (stay IDLE, no done).
//  FEED: combinational pass-through, zero latency.
//   am_xi=s_xi, am_xq=s_xq, am_valid=s_valid, s_ready=am_ready.
//   am_last = (count == len_q-1) while in FEED.
//   A beat transfers when s_valid & am_ready; count increments only on a transfer.
//   Transfer with am_last=1: go to WAIT, s_ready=0 from the next cycle.
//   No sample beyond frame_len is ever accepted.
//   s_valid may drop mid-frame; count holds.
//  WAIT: am_res_ready=1. When am_res_valid=1:
//   res_max<=am_max, res_index<=am_index, res_valid<=1, go to HOLD.
//   idx_err<=1 if am_index >= len_q.
//  HOLD: am_res_ready=0; res_max/res_index stable while res_valid=1.
//   res_valid & res_ready: res_valid<=0, done=1 for that cycle, go to IDLE.
//   IDLE is reached the cycle after the handshake.
//  start is ignored in FEED/WAIT/HOLD, including a start coincident with the HOLD handshake.
//  busy = (state != IDLE).
//  res_max/res_index retain their last values after the handshake.
//  Reset mid-frame: immediate return to IDLE; partial count is discarded;
//   the next frame begins at count=0.
//  count width = INDEX_BITS; frame_len = 2^INDEX_BITS-1 is legal with no wrap.
// TESTING
//  1. Reset, start with frame_len=8, 8 back-to-back samples, arg_max returns
//     max=500 index=5 -> am_last only on the 8th beat, res_valid=1 res_index=5,
//     done pulses once on res_ready.
//  2. Same frame, s_valid toggled 1/0 and am_ready low 3 cycles mid-frame ->
//     exactly 8 transfers, am_last on the 8th, no sample dropped or duplicated.
//  3. start with frame_len=0, and start pulses during FEED/HOLD ->
//     busy stays as-is, no extra frame, count unchanged.
//  4. frame_len=4, arg_max returns index=6 -> idx_err=1 sticky until the next
//     accepted start, which clears it.
//  5. res_ready held low 20 cycles in HOLD -> res_valid and result stable,
//     s_ready=0, am_res_ready=0 throughout.
//  6. rst asserted after 3 of 8 beats, then a new start with frame_len=2 ->
//     all outputs 0 at once, new frame am_last on its 2nd beat.

Source files
------------

// File: rtl/argmax_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_frame_ctrl_if
//  Description : Bundle of command, sample-stream, arg_max and result signals
//                around the arg_max frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface argmax_frame_ctrl_if #(
    parameter int I_BITS       = 16,
    parameter int Q_BITS       = 16,
    parameter int OUT_MAX_BITS = 33,
    parameter int INDEX_BITS   = 10
);
    logic                    start;
    logic [INDEX_BITS-1:0]   frame_len;
    logic [I_BITS-1:0]       s_xi;
    logic [Q_BITS-1:0]       s_xq;
    logic                    s_valid;
    logic                    s_ready;
    logic [I_BITS-1:0]       am_xi;
    logic [Q_BITS-1:0]       am_xq;
    logic                    am_valid;
    logic                    am_ready;
    logic                    am_last;
    logic [OUT_MAX_BITS-1:0] am_max;
    logic [INDEX_BITS-1:0]   am_index;
    logic                    am_res_valid;
    logic                    am_res_ready;
    logic [OUT_MAX_BITS-1:0] res_max;
    logic [INDEX_BITS-1:0]   res_index;
    logic                    res_valid;
    logic                    res_ready;
    logic                    busy;
    logic                    done;
    logic                    idx_err;

    // Environment side: drives commands, samples and results into the controller.
    modport master (
        output start, frame_len, s_xi, s_xq, s_valid, am_ready,
               am_max, am_index, am_res_valid, res_ready,
        input  s_ready, am_xi, am_xq, am_valid, am_last, am_res_ready,
               res_max, res_index, res_valid, busy, done, idx_err
    );

    // Controller side.
    modport slave (
        input  start, frame_len, s_xi, s_xq, s_valid, am_ready,
               am_max, am_index, am_res_valid, res_ready,
        output s_ready, am_xi, am_xq, am_valid, am_last, am_res_ready,
               res_max, res_index, res_valid, busy, done, idx_err
    );
endinterface
`default_nettype wire

// File: rtl/argmax_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_frame_ctrl
//  Description : Gates one frame of I/Q samples into arg_max, collects its
//                (max, index) result and holds it until downstream accepts.
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_frame_ctrl #(
    parameter int I_BITS       = 16,
    parameter int Q_BITS       = 16,
    parameter int OUT_MAX_BITS = 33,
    parameter int INDEX_BITS   = 10
) (
    input wire                 clk,
    input wire                 rst,
    argmax_frame_ctrl_if.slave bus
);

    localparam logic [INDEX_BITS-1:0] c_one = {{(INDEX_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                  r_state;
    logic [INDEX_BITS-1:0]   r_count;
    logic [INDEX_BITS-1:0]   r_len;
    logic [OUT_MAX_BITS-1:0] r_res_max;
    logic [INDEX_BITS-1:0]   r_res_index;
    logic                    r_res_valid;
    logic                    r_idx_err;

    logic                    w_feed;
    logic                    w_last;
    logic                    w_xfer;

    assign w_feed = (r_state == S_FEED);
    // r_len is never zero in FEED, so the subtraction cannot underflow.
    assign w_last = w_feed && (r_count == (r_len - c_one));
    assign w_xfer = w_feed && bus.s_valid && bus.am_ready;

    assign bus.s_ready      = w_feed && bus.am_ready;
    assign bus.am_valid     = w_feed && bus.s_valid;
    assign bus.am_xi        = w_feed ? bus.s_xi : {I_BITS{1'b0}};
    assign bus.am_xq        = w_feed ? bus.s_xq : {Q_BITS{1'b0}};
    assign bus.am_last      = w_last;
    assign bus.am_res_ready = (r_state == S_WAIT);
    assign bus.res_max      = r_res_max;
    assign bus.res_index    = r_res_index;
    assign bus.res_valid    = r_res_valid;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = (r_state == S_HOLD) && r_res_valid && bus.res_ready;
    assign bus.idx_err      = r_idx_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_len       <= '0;
            r_res_max   <= '0;
            r_res_index <= '0;
            r_res_valid <= 1'b0;
            r_idx_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.frame_len != '0)) begin
                        r_len     <= bus.frame_len;
                        r_count   <= '0;
                        r_idx_err <= 1'b0;
                        r_state   <= S_FEED;
                    end
                end
                S_FEED: begin
                    // Count stays on the last index so it never wraps at full length.
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.am_res_valid) begin
                        r_res_max   <= bus.am_max;
                        r_res_index <= bus.am_index;
                        r_res_valid <= 1'b1;
                        if (bus.am_index >= r_len) begin
                            r_idx_err <= 1'b1;
                        end
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_res_valid && bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_argmax_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_argmax_frame_ctrl
//  Description : Scoreboard bench for the arg_max frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_argmax_frame_ctrl;

    localparam int I_BITS       = 16;
    localparam int Q_BITS       = 16;
    localparam int OUT_MAX_BITS = 33;
    localparam int INDEX_BITS   = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    argmax_frame_ctrl_if #(
        .I_BITS(I_BITS), .Q_BITS(Q_BITS),
        .OUT_MAX_BITS(OUT_MAX_BITS), .INDEX_BITS(INDEX_BITS)
    ) bus ();

    argmax_frame_ctrl #(
        .I_BITS(I_BITS), .Q_BITS(Q_BITS),
        .OUT_MAX_BITS(OUT_MAX_BITS), .INDEX_BITS(INDEX_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [I_BITS-1:0] xi;
        logic [Q_BITS-1:0] xq;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic [OUT_MAX_BITS-1:0] mx;
        logic [INDEX_BITS-1:0]   idx;
    } res_t;

    beat_t beat_q[$];
    res_t  res_q[$];
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    done_cnt = 0;
    bit    tb_feed  = 1'b0;

    // Scoreboard side: every beat seen by arg_max and every accepted result.
    beat_t m_beat;
    res_t  m_res;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.am_valid && bus.am_ready) begin
                n_tests++;
                if (beat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: am_xi=%h am_last=%b, no sample expected", bus.am_xi, bus.am_last);
                end else begin
                    m_beat = beat_q.pop_front();
                    if ({bus.am_xi, bus.am_xq, bus.am_last} !== {m_beat.xi, m_beat.xq, m_beat.last}) begin
                        n_fail++;
                        $display("FAIL beat: got xi=%h xq=%h last=%b, expected xi=%h xq=%h last=%b",
                                 bus.am_xi, bus.am_xq, bus.am_last, m_beat.xi, m_beat.xq, m_beat.last);
                    end
                end
            end
            if (tb_feed) begin
                n_tests++;
                if (bus.s_ready !== bus.am_ready) begin
                    n_fail++;
                    $display("FAIL s_ready_feed: got %b expected %b", bus.s_ready, bus.am_ready);
                end
            end
            if (bus.done) begin
                done_cnt++;
                n_tests++;
                if (res_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_done: done=1 with no result expected");
                end else begin
                    m_res = res_q.pop_front();
                    if ({bus.res_max, bus.res_index, bus.res_valid} !== {m_res.mx, m_res.idx, 1'b1}) begin
                        n_fail++;
                        $display("FAIL result: got max=%0d idx=%0d valid=%b expected max=%0d idx=%0d valid=1",
                                 bus.res_max, bus.res_index, bus.res_valid, m_res.mx, m_res.idx);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len);
        logic [31:0] l;
        l             = len;
        bus.start     = 1'b1;
        bus.frame_len = l[INDEX_BITS-1:0];
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic feed_beats(input int n, input int len, input int first, input bit toggle, input bit stall);
        beat_t e;
        tb_feed = 1'b1;
        for (int k = 0; k < n; k++) begin
            e.xi   = I_BITS'($urandom);
            e.xq   = Q_BITS'($urandom);
            e.last = ((first + k) == (len - 1));
            beat_q.push_back(e);
            if (toggle && (k % 2 == 1)) begin
                bus.s_valid  = 1'b0;
                bus.s_xi     = ~e.xi;
                bus.am_ready = 1'b1;
                tick();
            end
            if (stall && ((first + k) == 3)) begin
                bus.s_valid  = 1'b1;
                bus.s_xi     = e.xi;
                bus.s_xq     = e.xq;
                bus.am_ready = 1'b0;
                repeat (3) tick();
            end
            bus.s_valid  = 1'b1;
            bus.am_ready = 1'b1;
            bus.s_xi     = e.xi;
            bus.s_xq     = e.xq;
            tick();
        end
        bus.s_valid = 1'b0;
        tb_feed     = 1'b0;
    endtask

    task automatic give_result(input logic [OUT_MAX_BITS-1:0] mx, input logic [INDEX_BITS-1:0] idx);
        res_t r;
        r.mx             = mx;
        r.idx            = idx;
        res_q.push_back(r);
        bus.am_max       = mx;
        bus.am_index     = idx;
        bus.am_res_valid = 1'b1;
        tick();
        bus.am_res_valid = 1'b0;
    endtask

    task automatic accept_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b1;
        bus.am_ready = 1'b1;
        bus.res_ready = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({bus.busy, bus.s_ready, bus.am_valid, bus.am_last, bus.am_res_ready,
             bus.res_valid, bus.done, bus.idx_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b s_ready=%b am_valid=%b am_last=%b am_res_ready=%b res_valid=%b done=%b idx_err=%b, all expected 0",
                     bus.busy, bus.s_ready, bus.am_valid, bus.am_last, bus.am_res_ready,
                     bus.res_valid, bus.done, bus.idx_err);
        end
        n_tests++;
        if ({bus.res_max, bus.res_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_result: max=%0d idx=%0d expected 0/0", bus.res_max, bus.res_index);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({bus.busy, bus.s_ready, bus.am_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b s_ready=%b am_valid=%b expected 000",
                     bus.busy, bus.s_ready, bus.am_valid);
        end
        bus.s_valid = 1'b0;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        start_frame(8);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b expected 1", bus.busy);
        end
        feed_beats(8, 8, 0, 1'b0, 1'b0);
        bus.s_valid = 1'b1;
        bus.am_ready = 1'b1;
        #1;
        n_tests++;
        if ({bus.am_res_ready, bus.s_ready, bus.res_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_wait: am_res_ready=%b s_ready=%b res_valid=%b expected 1 0 0",
                     bus.am_res_ready, bus.s_ready, bus.res_valid);
        end
        give_result(33'd500, 10'd5);
        bus.s_valid = 1'b0;
        n_tests++;
        if ({bus.res_valid, bus.res_max, bus.res_index, bus.am_res_ready, bus.idx_err}
            !== {1'b1, 33'd500, 10'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_hold: valid=%b max=%0d idx=%0d am_res_ready=%b idx_err=%b expected 1 500 5 0 0",
                     bus.res_valid, bus.res_max, bus.res_index, bus.am_res_ready, bus.idx_err);
        end
        accept_result();
        repeat (2) tick();
        n_tests++;
        if ({bus.busy, bus.res_valid, bus.res_max, bus.res_index} !== {1'b0, 1'b0, 33'd500, 10'd5}) begin
            n_fail++;
            $display("FAIL basic_after: busy=%b valid=%b max=%0d idx=%0d expected 0 0 500 5",
                     bus.busy, bus.res_valid, bus.res_max, bus.res_index);
        end
        n_tests++;
        if (done_cnt - d0 !== 1 || beat_q.size() !== 0) begin
            n_fail++;
            $display("FAIL basic_done_count: done pulses=%0d pending beats=%0d expected 1 and 0",
                     done_cnt - d0, beat_q.size());
        end
    endtask

    task automatic test_stall();
        int d0;
        d0 = done_cnt;
        start_frame(8);
        feed_beats(8, 8, 0, 1'b1, 1'b1);
        tick();
        n_tests++;
        if (beat_q.size() !== 0 || bus.am_res_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_beats: pending beats=%0d am_res_ready=%b expected 0 and 1",
                     beat_q.size(), bus.am_res_ready);
        end
        give_result(33'd77, 10'd2);
        accept_result();
        n_tests++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL stall_done: done pulses=%0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_ignored_start();
        int d0;
        d0 = done_cnt;
        start_frame(0);
        repeat (3) begin
            n_tests++;
            if (bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_len_start: busy=%b expected 0", bus.busy);
            end
            tick();
        end
        start_frame(4);
        bus.start = 1'b1;
        bus.frame_len = 10'd2;
        tick();
        bus.start = 1'b0;
        feed_beats(4, 4, 0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.busy, bus.am_res_ready} !== 2'b11 || beat_q.size() !== 0) begin
            n_fail++;
            $display("FAIL start_in_feed: busy=%b am_res_ready=%b pending=%0d expected 1 1 0",
                     bus.busy, bus.am_res_ready, beat_q.size());
        end
        give_result(33'd100, 10'd3);
        bus.start = 1'b1;
        bus.frame_len = 10'd6;
        tick();
        n_tests++;
        if ({bus.res_valid, bus.busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL start_in_hold: res_valid=%b busy=%b expected 1 1", bus.res_valid, bus.busy);
        end
        accept_result();
        bus.start = 1'b0;
        repeat (3) begin
            n_tests++;
            if ({bus.busy, bus.am_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL start_at_handshake: busy=%b am_valid=%b expected 0 0", bus.busy, bus.am_valid);
            end
            tick();
        end
        start_frame(1);
        feed_beats(1, 1, 0, 1'b0, 1'b0);
        give_result(33'd7, 10'd0);
        accept_result();
        n_tests++;
        if (done_cnt - d0 !== 2 || bus.idx_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_done: done pulses=%0d idx_err=%b expected 2 0", done_cnt - d0, bus.idx_err);
        end
    endtask

    task automatic test_idx_err();
        start_frame(4);
        feed_beats(4, 4, 0, 1'b0, 1'b0);
        give_result(33'd9999, 10'd6);
        n_tests++;
        if (bus.idx_err !== 1'b1) begin
            n_fail++;
            $display("FAIL idx_err_set: got %b expected 1", bus.idx_err);
        end
        accept_result();
        repeat (3) tick();
        n_tests++;
        if (bus.idx_err !== 1'b1) begin
            n_fail++;
            $display("FAIL idx_err_sticky: got %b expected 1", bus.idx_err);
        end
        start_frame(2);
        n_tests++;
        if (bus.idx_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idx_err_clear: got %b expected 0", bus.idx_err);
        end
        feed_beats(2, 2, 0, 1'b0, 1'b0);
        give_result(33'd1, 10'd2);
        n_tests++;
        if (bus.idx_err !== 1'b1) begin
            n_fail++;
            $display("FAIL idx_err_equal_len: got %b expected 1", bus.idx_err);
        end
        accept_result();
        start_frame(3);
        feed_beats(3, 3, 0, 1'b0, 1'b0);
        give_result(33'd1, 10'd2);
        n_tests++;
        if (bus.idx_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idx_err_in_range: got %b expected 0", bus.idx_err);
        end
        accept_result();
    endtask

    task automatic test_hold_stall();
        start_frame(5);
        feed_beats(5, 5, 0, 1'b1, 1'b0);
        give_result(33'h1_2345_6789, 10'd4);
        bus.s_valid = 1'b1;
        bus.am_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            n_tests++;
            if ({bus.res_valid, bus.res_max, bus.res_index, bus.s_ready, bus.am_res_ready, bus.done}
                !== {1'b1, 33'h1_2345_6789, 10'd4, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d: valid=%b max=%h idx=%0d s_ready=%b am_res_ready=%b done=%b expected 1 123456789 4 0 0 0",
                         c, bus.res_valid, bus.res_max, bus.res_index, bus.s_ready, bus.am_res_ready, bus.done);
            end
            tick();
        end
        bus.s_valid = 1'b0;
        accept_result();
    endtask

    task automatic test_reset_mid();
        start_frame(8);
        feed_beats(3, 8, 0, 1'b0, 1'b0);
        bus.s_valid = 1'b1;
        bus.am_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, bus.s_ready, bus.am_valid, bus.am_last, bus.am_res_ready,
             bus.res_valid, bus.done, bus.idx_err, bus.res_max, bus.res_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b s_ready=%b am_valid=%b res_valid=%b max=%0d idx=%0d expected all 0",
                     bus.busy, bus.s_ready, bus.am_valid, bus.res_valid, bus.res_max, bus.res_index);
        end
        bus.s_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        start_frame(2);
        feed_beats(2, 2, 0, 1'b0, 1'b0);
        n_tests++;
        if (bus.am_res_ready !== 1'b1 || beat_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_new_frame: am_res_ready=%b pending=%0d expected 1 0",
                     bus.am_res_ready, beat_q.size());
        end
        give_result(33'd10, 10'd1);
        accept_result();
    endtask

    task automatic test_max_len();
        start_frame(1023);
        feed_beats(1023, 1023, 0, 1'b0, 1'b0);
        n_tests++;
        if (bus.am_res_ready !== 1'b1 || beat_q.size() !== 0) begin
            n_fail++;
            $display("FAIL max_len_frame: am_res_ready=%b pending=%0d expected 1 0",
                     bus.am_res_ready, beat_q.size());
        end
        give_result(33'h1_FFFF_FFFF, 10'd1022);
        n_tests++;
        if (bus.idx_err !== 1'b0) begin
            n_fail++;
            $display("FAIL max_len_idx_err: got %b expected 0", bus.idx_err);
        end
        accept_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start        = 1'b0;
        bus.frame_len    = '0;
        bus.s_xi         = '0;
        bus.s_xq         = '0;
        bus.s_valid      = 1'b0;
        bus.am_ready     = 1'b1;
        bus.am_max       = '0;
        bus.am_index     = '0;
        bus.am_res_valid = 1'b0;
        bus.res_ready    = 1'b0;
        rst              = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_ignored_start();
        test_idx_err();
        test_hold_stall();
        test_reset_mid();
        test_max_len();
        repeat (2) tick();
        n_tests++;
        if (beat_q.size() !== 0 || res_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending beats=%0d results=%0d expected 0 0",
                     beat_q.size(), res_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
